// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: pc_src encodings, fault codes, FSM states and the reset NOP.
package instruction_fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned OPCODE_W     = 7;
    localparam int unsigned F3_W         = 3;
    localparam int unsigned F7_W         = 7;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4   = 2'b00,
        PC_SRC_BRANCH  = 2'b01,
        PC_SRC_JALR    = 2'b10,
        PC_SRC_ILLEGAL = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        FAULT_NONE        = 2'b00,
        FAULT_MISALIGNED  = 2'b01,
        FAULT_ILLEGAL_SRC = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: req/addr out, rdata/valid back.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_valid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/instruction_fetch_next_pc_gen.sv
// Combinational next-PC selection with misalignment and illegal-source detection.
module instruction_fetch_next_pc_gen
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  pc_src_e         pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output fault_e          fault
);

    always_comb begin
        next_pc = pc + XLEN'(4);
        fault   = FAULT_NONE;
        case (pc_src)
            PC_SRC_PLUS4:  next_pc = pc + XLEN'(4);
            PC_SRC_BRANCH: next_pc = pc + imm_ext;
            PC_SRC_JALR:   next_pc = alu_result & ~XLEN'(1);
            default: begin
                next_pc = pc;
                fault   = FAULT_ILLEGAL_SRC;
            end
        endcase
        // Both low bits checked: a branch offset can leave bit0 set.
        if (fault == FAULT_NONE && next_pc[1:0] != 2'b00) begin
            fault = FAULT_MISALIGNED;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/valid and holds the
// fetched word until the datapath commits it.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned   XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master imem_bus,
    input  logic                commit,
    input  logic [1:0]          pc_src,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic [XLEN-1:0]     alu_result,
    output logic                instr_valid,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [F3_W-1:0]     f3,
    output logic [F7_W-1:0]     f7,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                halted,
    output logic [1:0]          fault_cause
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            req_q, req_d;
    logic            halted_q, halted_d;
    fault_e          fault_q, fault_d;

    logic [XLEN-1:0] next_pc;
    fault_e          next_fault;

    instruction_fetch_next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
        .pc         (pc_q),
        .pc_src     (pc_src_e'(pc_src)),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .next_pc    (next_pc),
        .fault      (next_fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + XLEN'(4);
            instr_q       <= XLEN'(NOP_INSTR);
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= FAULT_NONE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            req_q         <= req_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    // A response only counts while our request is actually on the bus.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        req_d         = req_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        unique case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                if (req_q && imem_bus.imem_valid) begin
                    instr_d       = imem_bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    req_d         = 1'b0;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    instr_valid_d = 1'b0;
                    if (next_fault != FAULT_NONE) begin
                        halted_d = 1'b1;
                        fault_d  = next_fault;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d       = next_pc;
                        pc_plus4_d = next_pc + XLEN'(4);
                        req_d      = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            default: begin
                req_d         = 1'b0;
                instr_valid_d = 1'b0;
                halted_d      = 1'b1;
                state_d       = ST_HALT;
            end
        endcase
    end

    assign imem_bus.imem_req  = req_q;
    assign imem_bus.imem_addr = pc_q;
    assign instr_valid        = instr_valid_q;
    assign instr              = instr_q;
    assign opcode             = instr_q[6:0];
    assign f3                 = instr_q[14:12];
    assign f7                 = instr_q[31:25];
    assign pc                 = pc_q;
    assign pc_plus4           = pc_plus4_q;
    assign halted             = halted_q;
    assign fault_cause        = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a per-cycle reference model and a
// wait-state-programmable instruction memory.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm_ext = '0;
    logic [31:0] alu_result = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [1:0]  fault_cause;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_bus    (bus),
        .commit      (commit),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .f3          (f3),
        .f7          (f7),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .fault_cause (fault_cause)
    );

    // Memory: answers after wait_cycles of held request; force_valid injects stray strobes.
    logic [31:0] wait_cycles = '0;
    bit          force_valid = 1'b0;
    logic [31:0] wcnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[11:0], 20'h0};
    endfunction

    assign bus.imem_valid = force_valid | (bus.imem_req && (wcnt == wait_cycles));
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst)                                 wcnt <= '0;
        else if (bus.imem_req && !bus.imem_valid) wcnt <= wcnt + 32'd1;
        else                                     wcnt <= '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: fetching / holding / halted, stepped once per clock.
    logic [31:0] m_pc = '0, m_instr = 32'h13;
    logic        m_exec = 1'b0, m_req = 1'b0, m_halt = 1'b0;
    logic [1:0]  m_cause = 2'b00;

    function automatic logic [31:0] target(input logic [1:0] s, input logic [31:0] p,
                                           input logic [31:0] imm, input logic [31:0] alu);
        case (s)
            2'b00:   return p + 32'd4;
            2'b01:   return p + imm;
            default: return {alu[31:1], 1'b0};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= '0; m_instr <= 32'h13; m_exec <= 1'b0; m_req <= 1'b0;
            m_halt <= 1'b0; m_cause <= 2'b00;
        end else if (m_halt) begin
            m_req <= 1'b0;
        end else if (!m_exec) begin
            if (m_req && bus.imem_valid) begin
                m_instr <= bus.imem_rdata; m_exec <= 1'b1; m_req <= 1'b0;
            end else begin
                m_req <= 1'b1;
            end
        end else if (commit) begin
            if (pc_src == 2'b11) begin
                m_halt <= 1'b1; m_cause <= 2'b10;
            end else if (target(pc_src, m_pc, imm_ext, alu_result) % 4 != 0) begin
                m_halt <= 1'b1; m_cause <= 2'b01;
            end else begin
                m_pc   <= target(pc_src, m_pc, imm_ext, alu_result);
                m_exec <= 1'b0; m_req <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("imem_req",    32'(bus.imem_req), 32'(m_req));
            chk("imem_addr",   bus.imem_addr, m_pc);
            chk("instr_valid", 32'(instr_valid), 32'(m_exec && !m_halt));
            chk("instr",       instr, m_instr);
            chk("opcode",      32'(opcode), 32'(m_instr[6:0]));
            chk("f3",          32'(f3), 32'(m_instr[14:12]));
            chk("f7",          32'(f7), 32'(m_instr[31:25]));
            chk("pc",          pc, m_pc);
            chk("pc_plus4",    pc_plus4, m_pc + 32'd4);
            chk("halted",      32'(halted), 32'(m_halt));
            chk("fault_cause", 32'(fault_cause), 32'(m_cause));
        end
    end

    task automatic wait_exec(output int reqc);
        bit got = 1'b0;
        reqc = 0;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) begin got = 1'b1; break; end
            if (bus.imem_req) reqc++;
            @(negedge clk);
        end
        if (!got) chk("exec_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_commit(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] alu);
        #1;
        commit = 1'b1; pc_src = s; imm_ext = imm; alu_result = alu;
        @(negedge clk);
        #1;
        commit = 1'b0; pc_src = 2'b00; imm_ext = '0; alu_result = '0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic halt_pulses();
        #1 force_valid = 1'b1; commit = 1'b1;
        repeat (3) @(negedge clk);
        #1 force_valid = 1'b0; commit = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req",    32'(bus.imem_req), 32'd0);
        chk("rst_pc",     pc, 32'h0);
        chk("rst_instr",  instr, 32'h0000_0013);
        chk("rst_ivalid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #1 rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("first_req",  32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // Zero-wait stream, last commit arms a 3-wait-state fetch.
        for (int i = 0; i < 3; i++) begin
            wait_exec(n);
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_opcode", 32'(opcode), 32'h13);
            chk("seq_f3", 32'(f3), 32'h0);
            if (i == 0) chk("seq_instr0", instr, 32'h0050_0093);
            if (i == 2) wait_cycles = 32'd3;
            do_commit(2'b00, '0, '0);
        end
        wait_exec(n);
        chk("wait_req_cycles", 32'(n), 32'd4);
        chk("wait_pc", pc, 32'hC);
        wait_cycles = '0;
        do_commit(2'b00, '0, '0);
        wait_exec(n);
        chk("br_pc", pc, 32'h10);
        do_commit(2'b01, 32'hFFFF_FFF8, '0);
        chk("br_addr", bus.imem_addr, 32'h08);
        wait_exec(n);
        do_commit(2'b10, '0, 32'h105);
        chk("jalr_addr", bus.imem_addr, 32'h104);
        wait_exec(n);
        do_commit(2'b10, '0, 32'h106);
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_cause",  32'(fault_cause), 32'd1);
        chk("mis_pc",     pc, 32'h104);
        halt_pulses();
        chk("mis_hold_req", 32'(bus.imem_req), 32'd0);
        chk("mis_hold_pc",  pc, 32'h104);

        do_reset();
        wait_exec(n);
        do_commit(2'b11, '0, '0);
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_cause",  32'(fault_cause), 32'd2);
        chk("ill_pc",     pc, 32'h0);
        halt_pulses();
        chk("ill_hold_ivalid", 32'(instr_valid), 32'd0);

        // Wrap-around from the top of the address space.
        do_reset();
        wait_exec(n);
        do_commit(2'b01, 32'hFFFF_FFFC, '0);
        chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        wait_exec(n);
        do_commit(2'b00, '0, '0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_halted", 32'(halted), 32'd0);

        // Asynchronous reset with a request outstanding.
        wait_exec(n);
        wait_cycles = 32'd5;
        do_commit(2'b00, '0, '0);
        @(negedge clk);
        chk("mf_pre_req", 32'(bus.imem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mf_req",    32'(bus.imem_req), 32'd0);
        chk("mf_pc",     pc, 32'h0);
        chk("mf_pc4",    pc_plus4, 32'h4);
        chk("mf_instr",  instr, 32'h0000_0013);
        wait_cycles = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mf_restart_req",  32'(bus.imem_req), 32'd1);
        chk("mf_restart_addr", bus.imem_addr, 32'h0);

        // Asynchronous reset while holding an instruction.
        wait_exec(n);
        #1 rst = 1'b1;
        #1;
        chk("me_ivalid", 32'(instr_valid), 32'd0);
        chk("me_instr",  instr, 32'h0000_0013);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        wait_exec(n);
        chk("me_restart_pc", pc, 32'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
